// File: rtl/txs_write_arbiter_pkg.sv
// Shared constants and types for the txs burst-write arbitration path.
// Imported by the arbiter top and reusable by other txs-side arbiters.
package ovc_txs_pkg;

    localparam int TXS_NREQ      = 3;
    localparam int TXS_AW        = 22;
    localparam int TXS_DW        = 128;
    localparam int TXS_BCW       = 6;
    localparam int TXS_MAX_BURST = 32;

    localparam int CAM0 = 0;
    localparam int CAM1 = 1;
    localparam int IMU  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } arb_state_e;

endpackage

// File: rtl/txs_write_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after 'last'
// (wrapping modulo N) wins.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    int j;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last) + k) % N;
            if (!valid && req[IW'(j)]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/txs_write_arbiter.sv
// Round-robin owner of the PCIe txs Avalon-MM burst-write port. Each burst
// is granted whole; illegal lengths are rejected without touching txs.
module txs_write_arbiter
    import ovc_txs_pkg::*;
#(
    parameter int NREQ      = TXS_NREQ,
    parameter int AW        = TXS_AW,
    parameter int DW        = TXS_DW,
    parameter int BCW       = TXS_BCW,
    parameter int MAX_BURST = TXS_MAX_BURST
) (
    input  logic                c,
    input  logic                npor,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*BCW-1:0] req_len,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     beat_ack,
    output logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     rej,
    output logic                busy,
    output logic [AW-1:0]       txs_address,
    output logic [BCW-1:0]      txs_burstcount,
    output logic                txs_write,
    output logic [DW-1:0]       txs_writedata,
    input  logic                txs_waitrequest
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [BCW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             write_q, write_d;
    logic             busy_q, busy_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;

    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [BCW-1:0]   pick_len;
    logic [BCW-1:0]   own_len;
    logic             accept;
    logic             last_beat;
    logic [NREQ-1:0]  rej_c;

    function automatic logic len_ok(input logic [BCW-1:0] len);
        return (len != '0) && (int'(len) <= MAX_BURST);
    endfunction

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_len  = req_len[pick_idx*BCW +: BCW];
    assign own_len   = req_len[idx_q*BCW +: BCW];
    assign accept    = write_q & ~txs_waitrequest;
    assign last_beat = accept && (cnt_q == BCW'(1));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        write_d = write_q;
        busy_d  = busy_q;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        rej_c   = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (!len_ok(pick_len)) begin
                        rej_c[pick_idx] = 1'b1;
                        last_d          = pick_idx;
                    end else begin
                        idx_d   = pick_idx;
                        busy_d  = 1'b1;
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                // Address is forced to a 16-byte (one beat) boundary.
                gnt_d   = NREQ'(1) << idx_q;
                addr_d  = req_addr[idx_q*AW +: AW] & ~AW'(4'hF);
                bcnt_d  = own_len;
                cnt_d   = own_len;
                write_d = 1'b1;
                state_d = BURST;
            end
            BURST: begin
                if (accept) begin
                    cnt_d = cnt_q - BCW'(1);
                    if (last_beat) begin
                        write_d = 1'b0;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        last_d  = idx_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge c or negedge npor) begin
        if (!npor) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Pulses are derived from the registered grant so they clear with reset.
    assign beat_ack       = gnt_q & {NREQ{accept}};
    assign done           = gnt_q & {NREQ{last_beat}};
    assign rej            = rej_c & {NREQ{npor}};
    assign gnt            = gnt_q;
    assign busy           = busy_q;
    assign txs_write      = write_q;
    assign txs_address    = addr_q;
    assign txs_burstcount = bcnt_q;
    assign txs_writedata  = req_data[idx_q*DW +: DW];

endmodule

// File: doc/txs_write_arbiter.md
# txs_write_arbiter

Round-robin arbiter sharing the single PCIe TX-slave (txs) Avalon-MM burst-write port of the platform Qsys system among several DMA requesters: camera 0 line buffer, camera 1 line buffer, IMU sample buffer. Sits in the top-level datapath between the per-source buffers and the `pcie_txs_*` ports of the Qsys instance. Each burst is granted whole, and txs handshake rules are honoured. Runs entirely in the 125 MHz PCIe application clock domain.

## Interface
- `NREQ`, 3: number of requesters; index 0 = cam 0, 1 = cam 1, 2 = IMU.
- `AW`, 22: txs byte-address width.
- `DW`, 128: txs data width.
- `BCW`, 6: burstcount width.
- `MAX_BURST`, 32: largest legal burst length, in beats.

Ports:
- `c`  in  1  clock (pcie_clk_125).
- `npor`  in  1  reset, asynchronous, active-low.
- `req`  in  NREQ  per-requester burst request; held until `done` for that requester.
- `req_addr`  in  NREQ*AW  burst start byte address, slice i; bits [3:0] ignored.
- `req_len`  in  NREQ*BCW  burst length in beats, slice i.
- `req_data`  in  NREQ*DW  current beat, show-ahead, slice i.
- `gnt`  out  NREQ  one-hot; high for the whole owned burst.
- `beat_ack`  out  NREQ  pulse: current beat of requester i accepted; advance data.
- `done`  out  NREQ  pulse with the final `beat_ack` of a burst.
- `rej`  out  NREQ  pulse: request rejected because of an illegal length.
- `busy`  out  1  burst in progress.
- `txs_address`  out  AW  to Qsys.
- `txs_burstcount`  out  BCW  to Qsys.
- `txs_write`  out  1  to Qsys.
- `txs_writedata`  out  DW  to Qsys.
- `txs_waitrequest`  in  1  from Qsys.

## Operation
- States are IDLE, GRANT and BURST.
- **IDLE**
  - If any `req` is high, pick the winner with round-robin: search starts at `last+1` mod NREQ, where `last` is the most recently served or rejected index (reset value NREQ-1, so index 0 wins first).
  - If the winner's `req_len` is 0 or greater than MAX_BURST: pulse `rej[i]`, set `last = i`, stay in IDLE.
  - Otherwise, go to GRANT.
- **GRANT** (one cycle)
  - Register `gnt[i]`.
  - Register `txs_address = {req_addr_i[AW-1:4], 4'h0}` and `txs_burstcount = req_len_i`.
  - Load the beat counter with `req_len_i`.
  - Assert `txs_write`, then go to BURST.
- **BURST**
  - `txs_writedata` is a combinational mux of `req_data` slice i, selected by the registered grant.
  - A beat is accepted when `txs_write & ~txs_waitrequest`. On each accepted beat, pulse `beat_ack[i]` in the same cycle and decrement the counter.
  - On the beat with counter == 1:
    - pulse `done[i]`;
    - clear `txs_write` and `gnt`, registered for the next cycle;
    - set `last = i`;
    - go to IDLE.
  - `txs_address` and `txs_burstcount` are held for the entire burst. Per Avalon they are only sampled on the first beat; holding them keeps the bench simple.
- Requester contract:
  - `req`, `req_addr` and `req_len` are stable from assertion until `done`.
  - All beats are available, so there are no data bubbles: `txs_write` is never deasserted mid-burst.
  - Deasserting `req` mid-burst is illegal; the arbiter ignores it and completes the burst.
- Simultaneous requests from all sources are served 0→1→2→0. No requester waits more than NREQ-1 bursts.
- Reset, including mid-burst: all outputs clear asynchronously, state returns to IDLE and `last` returns to NREQ-1. The truncated PCIe transaction is the system's responsibility; PERST resets both sides.

## Timing
- Reset values: `gnt`, `beat_ack`, `done`, `rej`, `busy` and `txs_write` are 0; `txs_address` and `txs_burstcount` are 0.
- Latency: `req` sampled high in IDLE at edge N gives GRANT at N+1. `txs_write` and `gnt` are visible after edge N+1, and the first beat can be accepted at edge N+2.
- With `txs_waitrequest` low, an L-beat burst occupies L consecutive cycles. There are 2 overhead cycles (IDLE, GRANT) between bursts.
- `busy` is high in GRANT and BURST.
- `rej` costs one IDLE cycle per rejection.
- `beat_ack`, `done` and `rej` are combinational-from-state pulses, one cycle wide. All other outputs are registered, except `txs_writedata`.

## Structure
- Shared package `ovc_txs_pkg`:
  - width constants AW/DW/BCW/MAX_BURST;
  - requester index constants CAM0/CAM1/IMU;
  - state enum (IDLE, GRANT, BURST).
- Sub-module `rr_pick`: parameterised round-robin priority picker. Inputs are `req` and `last`; outputs are `valid` and the winner index. It is purely combinational, reused by the planned IRQ arbiter.

## Test plan
- Single request: `req[0]`, addr 0x000100, len 4, waitrequest low → `txs_write` high 4 cycles starting 2 cycles after req. Address 0x000100, burstcount 4, 4 `beat_ack[0]`, `done[0]` on the 4th beat.
- Backpressure: len 2, waitrequest high for the first 3 cycles of BURST → write, address and data held stable. Exactly 2 acks, burst ends in cycle 5.
- Fairness: all three requests held continuously with len 1 → grant order 0,1,2,0,1,2. Gap is 2 cycles between bursts.
- Illegal length: `req[1]` with len 0, then len 33 → one `rej[1]` pulse each, no `txs_write`. A simultaneous `req[2]` with len 8 is served next.
- Unaligned address: req_addr 0x00010F → `txs_address` = 0x000100.
- Reset mid-burst: `npor` low on beat 3 of 8 → `txs_write`, `gnt` and `busy` go to 0 immediately. After release, `req[0]` wins first.
